fsm_run_detector: RTL and testbench
===================================

# fsm_run_detector

Parametrised Moore run-length detector, successor to the single-input fixed-length sequence FSM used in the FSM lab. Samples serial input `X` on each rising `clock` edge and asserts `Y1` once `RUN_LEN` consecutive 0s have been seen and `Y2` once `RUN_LEN` consecutive 1s have been seen. Adds a sample-enable, a live run-length output, and saturating per-polarity hit counters. Sits directly behind a serial bit source; outputs feed status logic or LEDs.

## Interface
- `RUN_LEN`, 4: run length that triggers detection; legal range 2..255.
- `CNT_W`, 8: width of the hit counters `zero_hits` and `one_hits`.
- `clock`  in  1  rising-edge system clock.
- `reset_n`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `X`  in  1  serial data bit.
- `enable`  in  1  sample qualifier; `X` is ignored on any edge where `enable`=0.
- `Y1`  out  1  zero-run detected.
- `Y2`  out  1  one-run detected.
- `run_len`  out  8  length of the current run, saturating at 255.
- `zero_hits`  out  `CNT_W`  number of zero-run detections, saturating.
- `one_hits`  out  `CNT_W`  number of one-run detections, saturating.

## Operation
- States: `IDLE`, `ZRUN`, `ORUN`, `ZHIT`, `OHIT`. Encoding is free. State and all outputs are registered.
- Transition rules apply only on edges where `enable`=1. When `enable`=0, state and all outputs hold.
- From `IDLE`:
  - `X`=0 → `ZRUN` with `run_len`=1.
  - `X`=1 → `ORUN` with `run_len`=1.
- In `ZRUN`, when `X`=0:
  - `run_len` increments.
  - When the new value equals `RUN_LEN`, go to `ZHIT` and increment `zero_hits`.
- In `ZRUN`, when `X`=1: go to `ORUN` with `run_len`=1.
- `ORUN` mirrors `ZRUN`: target state `OHIT`, counter `one_hits`.
- `ZHIT`, `X`=0: stay in `ZHIT`. `run_len` keeps incrementing (saturating). No additional hit is counted; a run counts exactly once.
- `ZHIT`, `X`=1: go to `ORUN` with `run_len`=1. `OHIT` mirrors this.
- `Y1` = (state == `ZHIT`). `Y2` = (state == `OHIT`). `Y1` and `Y2` are never both 1.
- Non-0/1 `X` (X/Z) while `enable`=1: treated as a run break. Go to `IDLE`, `run_len`=0, counters unchanged.
- Counters and `run_len` saturate at all-ones and never wrap.

## Timing
- Reset values: state `IDLE`, `Y1`=0, `Y2`=0, `run_len`=0, `zero_hits`=0, `one_hits`=0.
- Reset is synchronous. Asserting `reset_n`=0 mid-run clears everything at the next edge. Reset wins over `enable` and `X`.
- Detection latency is zero extra cycles: `Y1` is high immediately after the edge that samples the `RUN_LEN`-th consecutive 0.
- On a polarity change, `Y1`/`Y2` drop immediately after the edge that samples the opposite bit.
- `enable` low inside a run does not break the run. The run continues on the next enabled sample.

## Configuration
- `FSM_RUN_STICKY_EN` defined:
  - `Y1`/`Y2` are held flags.
  - A flag is set on entry to `ZHIT`/`OHIT`.
  - A flag is cleared only by reset or by the opposite detection: `Y2` set clears `Y1`, and vice versa.
  - The flag persists through runs of the opposite bit shorter than `RUN_LEN`.
  - State machine, `run_len` and counters are unchanged.
- `FSM_RUN_STICKY_EN` undefined: `Y1`/`Y2` are pure state decodes, as described in Operation.

## Test plan
- Reset check: `reset_n`=0 for 2 edges, then release with `X`=0, `RUN_LEN`=4 → `Y1` rises after the 4th edge; `zero_hits`=1, `run_len`=4.
- Short runs: alternating runs of length 1, 2, 3 of each polarity → `Y1`=`Y2`=0 throughout; counters stay 0; `run_len` peaks at 3.
- Long run then flip: 10 zeros then one 1 → `Y1` high on edges 4..10; `zero_hits`=1; after the 1, `Y1`=0 and `run_len`=1.
- Enable gap: 2 zeros, `enable`=0 for 5 edges with `X`=1, then 2 zeros → `Y1` rises on the 4th enabled zero.
- Saturation and abort: `CNT_W`=2, 5 separate one-runs → `one_hits`=3. Reset asserted mid-run → all outputs 0 on the next edge.
- Sticky build with `FSM_RUN_STICKY_EN`: 4 zeros then 3 ones → `Y1` stays 1. A 4th one → `Y1`=0 and `Y2`=1 on the same edge.

Source files
------------

// File: rtl/fsm_run_detector.sv
// Moore run-length detector: flags RUN_LEN consecutive 0s (Y1) or 1s (Y2),
// reports the live run length and keeps saturating per-polarity hit counters.
// Optional build macro: FSM_RUN_STICKY_EN turns Y1/Y2 into held flags that are
// cleared only by reset or by the opposite detection.
module fsm_run_detector #(
  parameter int unsigned RUN_LEN = 4,  // legal range 2..255
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             X,
  input  logic             enable,
  output logic             Y1,
  output logic             Y2,
  output logic [7:0]       run_len,
  output logic [CNT_W-1:0] zero_hits,
  output logic [CNT_W-1:0] one_hits
);

  typedef enum logic [2:0] {StIdle, StZrun, StOrun, StZhit, StOhit} state_e;

  localparam logic [7:0] RunTarget = 8'(RUN_LEN);

  state_e             state_q, state_d;
  logic [7:0]         run_len_q, run_len_d;
  logic [CNT_W-1:0]   zero_hits_q, zero_hits_d;
  logic [CNT_W-1:0]   one_hits_q, one_hits_d;
  logic               y1_q, y1_d;
  logic               y2_q, y2_d;

  logic [7:0]         run_len_inc;
  logic [CNT_W-1:0]   zero_hits_inc;
  logic [CNT_W-1:0]   one_hits_inc;

  // Saturating increments of the run length and both hit counters.
  always_comb begin
    run_len_inc   = (run_len_q == 8'hFF) ? run_len_q : run_len_q + 8'd1;
    zero_hits_inc = (&zero_hits_q) ? zero_hits_q : zero_hits_q + CNT_W'(1);
    one_hits_inc  = (&one_hits_q) ? one_hits_q : one_hits_q + CNT_W'(1);
  end

  // Next-state, run length, counters and output flags; everything holds when enable=0.
  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    zero_hits_d = zero_hits_q;
    one_hits_d  = one_hits_q;
    y1_d        = y1_q;
    y2_d        = y2_q;

    if (enable) begin
      case (X)
        1'b0: begin
          if (state_q == StZrun || state_q == StZhit) begin
            run_len_d = run_len_inc;
            // A run counts once: only the ZRUN->ZHIT crossing bumps the counter.
            if (state_q == StZrun && run_len_inc == RunTarget) begin
              state_d     = StZhit;
              zero_hits_d = zero_hits_inc;
            end
          end else begin
            state_d   = StZrun;
            run_len_d = 8'd1;
          end
        end
        1'b1: begin
          if (state_q == StOrun || state_q == StOhit) begin
            run_len_d = run_len_inc;
            if (state_q == StOrun && run_len_inc == RunTarget) begin
              state_d    = StOhit;
              one_hits_d = one_hits_inc;
            end
          end else begin
            state_d   = StOrun;
            run_len_d = 8'd1;
          end
        end
        default: begin
          // Unknown input breaks the run without touching the counters.
          state_d   = StIdle;
          run_len_d = 8'd0;
        end
      endcase
    end

`ifdef FSM_RUN_STICKY_EN
    // Flags latch on entry to a hit state; each detection clears the other flag.
    if (state_d == StZhit && state_q != StZhit) begin
      y1_d = 1'b1;
      y2_d = 1'b0;
    end
    if (state_d == StOhit && state_q != StOhit) begin
      y1_d = 1'b0;
      y2_d = 1'b1;
    end
`else
    y1_d = (state_d == StZhit);
    y2_d = (state_d == StOhit);
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      run_len_q   <= 8'd0;
      zero_hits_q <= '0;
      one_hits_q  <= '0;
      y1_q        <= 1'b0;
      y2_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      zero_hits_q <= zero_hits_d;
      one_hits_q  <= one_hits_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
    end
  end

  assign Y1        = y1_q;
  assign Y2        = y2_q;
  assign run_len   = run_len_q;
  assign zero_hits = zero_hits_q;
  assign one_hits  = one_hits_q;

endmodule

// File: tb/tb_fsm_run_detector.sv
// Directed bench for fsm_run_detector (RUN_LEN=4, CNT_W=2 so counters saturate at 3).
// Expected values are hand-derived; a few differ when FSM_RUN_STICKY_EN is defined.
module tb_fsm_run_detector;

  localparam int unsigned RunLen = 4;
  localparam int unsigned CntW   = 2;
`ifdef FSM_RUN_STICKY_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  logic            clock;
  logic            reset_n;
  logic            x;
  logic            enable;
  logic            y1;
  logic            y2;
  logic [7:0]      run_len;
  logic [CntW-1:0] zero_hits;
  logic [CntW-1:0] one_hits;

  int unsigned n_cmp;
  int unsigned n_err;

  fsm_run_detector #(
    .RUN_LEN(RunLen),
    .CNT_W  (CntW)
  ) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .X        (x),
    .enable   (enable),
    .Y1       (y1),
    .Y2       (y2),
    .run_len  (run_len),
    .zero_hits(zero_hits),
    .one_hits (one_hits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one sample, clock it, then compare all outputs 1ns after the edge.
  task automatic step(input string tag, input logic xi, input logic en, input bit ey1,
                      input bit ey2, input int unsigned erl, input int unsigned ezh,
                      input int unsigned eoh);
    x      = xi;
    enable = en;
    @(posedge clock);
    #1;
    check_eq({tag, ".y1"}, 32'(y1), 32'(ey1));
    check_eq({tag, ".y2"}, 32'(y2), 32'(ey2));
    check_eq({tag, ".run_len"}, 32'(run_len), erl);
    check_eq({tag, ".zero_hits"}, 32'(zero_hits), ezh);
    check_eq({tag, ".one_hits"}, 32'(one_hits), eoh);
  endtask

  // Hold reset for n edges with arbitrary x/enable, check the cleared state, then release.
  task automatic do_reset(input string tag, input int unsigned n, input logic xi, input logic en);
    reset_n = 1'b0;
    x       = xi;
    enable  = en;
    for (int i = 0; i < int'(n); i++) begin
      @(posedge clock);
    end
    #1;
    check_eq({tag, ".y1"}, 32'(y1), 0);
    check_eq({tag, ".y2"}, 32'(y2), 0);
    check_eq({tag, ".run_len"}, 32'(run_len), 0);
    check_eq({tag, ".zero_hits"}, 32'(zero_hits), 0);
    check_eq({tag, ".one_hits"}, 32'(one_hits), 0);
    reset_n = 1'b1;
  endtask

  function automatic int unsigned sat3(input int unsigned v);
    return (v > 3) ? 3 : v;
  endfunction

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    x       = 1'b0;
    enable  = 1'b0;

    // Reset, then four zeros: Y1 rises after the 4th edge.
    do_reset("rst", 2, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step("rst_z", 1'b0, 1'b1, i == 4, 1'b0, i, (i == 4) ? 1 : 0, 0);
    end

    // Short runs of 1, 2, 3 of each polarity: no detections.
    do_reset("short_rst", 1, 1'b0, 1'b0);
    for (int len = 1; len <= 3; len++) begin
      for (int i = 1; i <= len; i++) step("short_z", 1'b0, 1'b1, 1'b0, 1'b0, i, 0, 0);
      for (int i = 1; i <= len; i++) step("short_o", 1'b1, 1'b1, 1'b0, 1'b0, i, 0, 0);
    end

    // Ten zeros then a one.
    do_reset("long_rst", 1, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step("long_z", 1'b0, 1'b1, i >= 4, 1'b0, i, (i >= 4) ? 1 : 0, 0);
    end
    step("long_flip", 1'b1, 1'b1, Sticky, 1'b0, 1, 1, 0);

    // Enable gap inside a zero run does not break it.
    do_reset("gap_rst", 1, 1'b0, 1'b1);
    step("gap_z1", 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0);
    step("gap_z2", 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0);
    for (int i = 0; i < 5; i++) step("gap_off", 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 0);
    step("gap_z3", 1'b0, 1'b1, 1'b0, 1'b0, 3, 0, 0);
    step("gap_z4", 1'b0, 1'b1, 1'b1, 1'b0, 4, 1, 0);

    // Five separate one-runs: 2-bit counter saturates at 3.
    do_reset("sat_rst", 1, 1'b1, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 1; i <= 4; i++) begin
        step("sat_o", 1'b1, 1'b1, 1'b0, (i == 4) || (Sticky && r > 0), i, 0,
             (i == 4) ? sat3(r + 1) : sat3(r));
      end
      step("sat_brk", 1'b0, 1'b1, 1'b0, Sticky, 1, 0, sat3(r + 1));
    end
    // Mid-run abort: reset wins over enable and X.
    step("abort_o1", 1'b1, 1'b1, 1'b0, Sticky, 1, 0, 3);
    step("abort_o2", 1'b1, 1'b1, 1'b0, Sticky, 2, 0, 3);
    do_reset("abort", 1, 1'b1, 1'b1);

    // Sticky scenario: four zeros, three ones, then the 4th one flips the flags.
    for (int i = 1; i <= 4; i++) begin
      step("stk_z", 1'b0, 1'b1, i == 4, 1'b0, i, (i == 4) ? 1 : 0, 0);
    end
    for (int i = 1; i <= 3; i++) step("stk_o", 1'b1, 1'b1, Sticky, 1'b0, i, 1, 0);
    step("stk_o4", 1'b1, 1'b1, 1'b0, 1'b1, 4, 1, 1);
    // Held enable=0 keeps everything, including the flag.
    step("stk_hold", 1'b0, 1'b0, 1'b0, 1'b1, 4, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
